// File: rtl/pc_redirect_unit.sv
// -----------------------------------------------------------------------------
// pc_redirect_unit
//
// Program-counter register and next-PC sequencer. It sits between EX-stage
// branch resolution and instruction memory. Each cycle it picks the next fetch
// address from sequential fetch, a taken branch, or a jump. After every
// redirect it squashes the IF/ID and ID/EX registers for FLUSH_CYCLES cycles.
// It also handles halt/resume sequencing for ECALL/EBREAK.
//
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   : a redirect to a target with bits[1:0] != 0 is not taken. The
//               unit halts and raises misalign until resume.
//   undefined : target bits[1:0] are forced to 00 and misalign is tied low.
//
// Parameters
//   XLEN          datapath / PC width
//   RESET_PC      PC value loaded on reset
//   FLUSH_CYCLES  cycles of flush assertion after a redirect (1..7)
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   stall          in   hazard-unit hold of PC (ignored in HALT)
//   branch_valid   in   EX holds a conditional branch
//   branch_taken   in   branch decision from the branch control unit
//   branch_target  in   EX-computed branch target
//   jump_valid     in   EX holds JAL/JALR (wins over a branch)
//   jump_target    in   EX-computed jump target (bit0 cleared on use)
//   halt_req       in   EX holds ECALL/EBREAK
//   resume         in   leave HALT
//   pc_out         out  current fetch address (registered)
//   pc_plus4       out  pc_out + 4, combinational, wraps modulo 2^XLEN
//   flush_ifid     out  squash IF/ID register
//   flush_idex     out  squash ID/EX register
//   redirect       out  one-cycle pulse in the first cycle after a redirect
//   halted         out  high while in HALT
//   redirect_cnt   out  saturating count of redirects taken
//   misalign       out  misaligned-target trap flag
// -----------------------------------------------------------------------------
module pc_redirect_unit #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_PC     = {XLEN{1'b0}},
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_valid,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump_valid,
    input  logic [XLEN-1:0] jump_target,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            redirect,
    output logic            halted,
    output logic [15:0]     redirect_cnt,
    output logic            misalign
);

    // Sequencer states
    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // The counter is loaded on the redirect edge, so the flush window counts
    // the redirect cycle itself plus FLUSH_CYCLES-1 cycles spent in FLUSH.
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [1:0] REDIR_NEXT = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

    logic [1:0]      r_state;
    logic [2:0]      r_cnt;
    logic [XLEN-1:0] r_pc;
    logic            r_flush;
    logic            r_redirect;
    logic            r_halted;
    logic [15:0]     r_redirect_cnt;

    logic            w_redir;
    logic [XLEN-1:0] w_target_raw;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_seq;
    logic            w_trap;

    assign w_redir    = jump_valid | (branch_valid & branch_taken);
    assign w_pc_plus4 = r_pc + XLEN'(4);
    // Sequential fetch, held by the hazard unit when stalled.
    assign w_pc_seq   = stall ? r_pc : w_pc_plus4;

    // A jump wins over a branch in the same cycle. JALR semantics clear bit0.
    assign w_target_raw = jump_valid ? {jump_target[XLEN-1:1], 1'b0} : branch_target;

`ifdef PC_MISALIGN_TRAP_EN
    logic r_misalign;

    // Any redirect whose final target is not word aligned traps rather than
    // loading the PC.
    assign w_trap   = w_redir & (|w_target_raw[1:0]);
    assign w_target = w_target_raw;
    assign misalign = r_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (r_state == ST_HALT) begin
            if (resume) begin
                r_misalign <= 1'b0;
            end
        end else if (r_state == ST_RUN && !halt_req && w_trap) begin
            r_misalign <= 1'b1;
        end
    end
`else
    // Without the trap, misaligned targets are silently word aligned.
    assign w_trap   = 1'b0;
    assign w_target = {w_target_raw[XLEN-1:2], 2'b00};
    assign misalign = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so that every branch
    // of the sequencer samples the pre-edge values of r_pc/r_cnt consistently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_cnt          <= 3'd0;
            r_pc           <= RESET_PC;
            r_flush        <= 1'b0;
            r_redirect     <= 1'b0;
            r_halted       <= 1'b0;
            r_redirect_cnt <= 16'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (halt_req) begin
                        // ECALL/EBREAK: freeze the PC where it stands.
                        r_state    <= ST_HALT;
                        r_halted   <= 1'b1;
                        r_flush    <= 1'b0;
                        r_redirect <= 1'b0;
                    end else if (w_trap) begin
                        // Misaligned redirect: no PC load, no flush, no count.
                        r_state    <= ST_HALT;
                        r_halted   <= 1'b1;
                        r_flush    <= 1'b0;
                        r_redirect <= 1'b0;
                    end else if (w_redir) begin
                        // A redirect beats stall. The younger instructions
                        // already in IF/ID and ID/EX are from the wrong path.
                        r_pc       <= w_target;
                        r_flush    <= 1'b1;
                        r_redirect <= 1'b1;
                        r_cnt      <= FLUSH_INIT;
                        r_state    <= REDIR_NEXT;
                        if (r_redirect_cnt != 16'hFFFF) begin
                            r_redirect_cnt <= r_redirect_cnt + 16'd1;
                        end
                    end else begin
                        // With FLUSH_CYCLES == 1 this also ends the flush.
                        r_pc       <= w_pc_seq;
                        r_flush    <= 1'b0;
                        r_redirect <= 1'b0;
                    end
                end

                ST_FLUSH: begin
                    // Branch, jump and halt requests here come from squashed
                    // instructions, so they are ignored.
                    r_pc       <= w_pc_seq;
                    r_redirect <= 1'b0;
                    if (r_cnt == 3'd0) begin
                        r_state <= ST_RUN;
                        r_flush <= 1'b0;
                    end else begin
                        // The counter runs even under stall, so the flush
                        // length is fixed in cycles.
                        r_cnt <= r_cnt - 3'd1;
                    end
                end

                ST_HALT: begin
                    // The PC is frozen and stall has no effect. Debug software
                    // moves the PC with a redirect after resume.
                    if (resume) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end

                default: begin
                    r_state    <= ST_RUN;
                    r_flush    <= 1'b0;
                    r_redirect <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out       = r_pc;
    assign pc_plus4     = w_pc_plus4;
    assign flush_ifid   = r_flush;
    assign flush_idex   = r_flush;
    assign redirect     = r_redirect;
    assign halted       = r_halted;
    assign redirect_cnt = r_redirect_cnt;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_redirect_unit
//
// Testbench for pc_redirect_unit with two instances:
//   dut  (FLUSH_CYCLES = 2): directed scenarios followed by random traffic.
//        Every cycle is compared with a cycle-level behavioural model.
//   dut2 (FLUSH_CYCLES = 1): a redirect on every cycle, run concurrently, to
//        drive redirect_cnt into saturation.
// The model follows PC_MISALIGN_TRAP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_pc_redirect_unit;

    localparam int FC = 2;
`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // ---- main instance ----
    logic        rst, stall, branch_valid, branch_taken, jump_valid, halt_req, resume;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc_out, pc_plus4;
    logic        flush_ifid, flush_idex, redirect, halted, misalign;
    logic [15:0] redirect_cnt;

    pc_redirect_unit #(.XLEN(32), .RESET_PC(32'h0), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_valid(branch_valid), .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jump_valid(jump_valid), .jump_target(jump_target),
        .halt_req(halt_req), .resume(resume),
        .pc_out(pc_out), .pc_plus4(pc_plus4),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .redirect(redirect), .halted(halted),
        .redirect_cnt(redirect_cnt), .misalign(misalign)
    );

    // ---- saturation instance ----
    logic        s2_rst, s2_jump_valid;
    logic [31:0] s2_jump_target;
    logic        s2_zero = 1'b0;
    logic [31:0] s2_zero32 = 32'h0;
    logic [31:0] s2_pc, s2_pc4;
    logic        s2_fi, s2_fd, s2_redir, s2_halted, s2_mis;
    logic [15:0] s2_cnt;

    pc_redirect_unit #(.XLEN(32), .RESET_PC(32'h0), .FLUSH_CYCLES(1)) dut2 (
        .clk(clk), .rst(s2_rst), .stall(s2_zero),
        .branch_valid(s2_zero), .branch_taken(s2_zero),
        .branch_target(s2_zero32),
        .jump_valid(s2_jump_valid), .jump_target(s2_jump_target),
        .halt_req(s2_zero), .resume(s2_zero),
        .pc_out(s2_pc), .pc_plus4(s2_pc4),
        .flush_ifid(s2_fi), .flush_idex(s2_fd),
        .redirect(s2_redir), .halted(s2_halted),
        .redirect_cnt(s2_cnt), .misalign(s2_mis)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---- behavioural model of the main instance ----
    // m_flush_left: number of cycles, from the current one, that the flush
    // outputs stay high.
    logic [31:0] m_pc;
    int          m_flush_left;
    bit          m_halted, m_mis, m_redir;
    int          m_cnt;

    task automatic model_update();
        logic [31:0] tgt;
        if (rst) begin
            m_pc = 32'h0; m_flush_left = 0; m_halted = 0; m_mis = 0;
            m_redir = 0; m_cnt = 0;
        end else if (m_halted) begin
            m_redir = 0;
            if (resume) begin m_halted = 0; m_mis = 0; end
        end else if (FC > 1 && m_flush_left > 0) begin
            // Inside the flush window the instructions are squashed.
            m_flush_left--;
            m_redir = 0;
            if (!stall) m_pc = m_pc + 32'd4;
        end else begin
            m_redir = 0;
            if (halt_req) begin
                m_halted = 1; m_flush_left = 0;
            end else if (jump_valid || (branch_valid && branch_taken)) begin
                tgt = jump_valid ? (jump_target & ~32'd1) : branch_target;
                if (TRAP && (tgt % 4) != 0) begin
                    m_halted = 1; m_mis = 1; m_flush_left = 0;
                end else begin
                    m_pc = tgt & ~32'd3;
                    m_flush_left = FC;
                    m_redir = 1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end else begin
                m_flush_left = 0;
                if (!stall) m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_all();
        check("pc_out",       pc_out,              m_pc);
        check("pc_plus4",     pc_plus4,            m_pc + 32'd4);
        check("flush_ifid",   32'(flush_ifid),     32'(m_flush_left > 0));
        check("flush_idex",   32'(flush_idex),     32'(m_flush_left > 0));
        check("redirect",     32'(redirect),       32'(m_redir));
        check("halted",       32'(halted),         32'(m_halted));
        check("redirect_cnt", 32'(redirect_cnt),   32'(m_cnt));
        check("misalign",     32'(misalign),       32'(m_mis));
    endtask

    // Inputs are set before the call, applied at the next rising edge, and
    // the outputs are compared 1 ns after that edge.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; branch_valid = 0; branch_taken = 0; jump_valid = 0;
        halt_req = 0; resume = 0; branch_target = 32'h0; jump_target = 32'h0;
    endtask

    task automatic main_seq();
        idle_inputs();
        rst = 1;
        @(negedge clk);
        tick();
        rst = 0;
        // Reset state followed by free-running fetch.
        for (int i = 0; i < 4; i++) tick();
        check("tp1_pc_0x10", pc_out, 32'h10);

        // Taken branch to 0x100: two flush cycles, one redirect pulse.
        branch_valid = 1; branch_taken = 1; branch_target = 32'h100;
        tick();
        idle_inputs();
        check("tp2_pc_0x100", pc_out, 32'h100);
        tick(); tick(); tick();
        check("tp2_pc_0x10c", pc_out, 32'h10c);
        // Not-taken branch: sequential fetch with no flush.
        branch_valid = 1; branch_taken = 0; branch_target = 32'h700;
        tick();
        idle_inputs();
        tick();

        // Jump and taken branch in the same cycle, with stall.
        jump_valid = 1; jump_target = 32'h203;
        branch_valid = 1; branch_taken = 1; branch_target = 32'h300; stall = 1;
        tick();
        idle_inputs();
        tick();
        resume = 1; tick(); resume = 0;
        tick(); tick(); tick();

        // Requests that arrive during FLUSH are ignored; stall during FLUSH.
        jump_valid = 1; jump_target = 32'h80;
        tick();
        jump_valid = 0;
        branch_valid = 1; branch_taken = 1; branch_target = 32'h500; halt_req = 1;
        tick();
        idle_inputs();
        stall = 1;
        tick();
        stall = 0;
        tick(); tick();

        // Halt at 0x40 for 10 cycles, stall ignored, then resume.
        jump_valid = 1; jump_target = 32'h38;
        tick();
        idle_inputs();
        tick(); tick();
        check("tp5_pc_0x40", pc_out, 32'h40);
        halt_req = 1;
        tick();
        halt_req = 0;
        for (int i = 0; i < 10; i++) begin
            stall = 1'($urandom_range(0, 1));
            tick();
        end
        stall = 0; resume = 1;
        tick();
        resume = 0;
        tick();
        check("tp5_pc_0x44", pc_out, 32'h44);

        // Reset in the middle of FLUSH and in the middle of HALT.
        jump_valid = 1; jump_target = 32'h600;
        tick();
        idle_inputs();
        rst = 1; tick(); rst = 0; tick();
        halt_req = 1; tick(); halt_req = 0;
        rst = 1; tick(); rst = 0; tick();

        // PC wraps from 0xFFFF_FFFC to 0.
        jump_valid = 1; jump_target = 32'hFFFF_FFF8;
        tick();
        idle_inputs();
        tick(); tick(); tick();

        // Misaligned branch target: trap when enabled, word aligned otherwise.
        branch_valid = 1; branch_taken = 1; branch_target = 32'h102;
        tick();
        idle_inputs();
        tick(); tick();
        resume = 1; tick(); resume = 0;
        tick(); tick(); tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 199) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_valid  = ($urandom_range(0, 4) == 0);
            branch_taken  = 1'($urandom_range(0, 1));
            jump_valid    = ($urandom_range(0, 9) == 0);
            halt_req      = ($urandom_range(0, 39) == 0);
            resume        = ($urandom_range(0, 4) == 0);
            branch_target = $urandom;
            jump_target   = $urandom;
            if ($urandom_range(0, 1) == 0) branch_target[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 0) jump_target[1:0]   = 2'b00;
            tick();
        end
        idle_inputs();
    endtask

    // Issue a redirect every cycle on the FLUSH_CYCLES = 1 instance.
    task automatic sat_seq();
        s2_rst = 1; s2_jump_valid = 0; s2_jump_target = 32'h0;
        @(negedge clk);
        @(posedge clk); #1;
        check("sat_reset_cnt", 32'(s2_cnt), 32'h0);
        @(negedge clk);
        s2_rst = 0; s2_jump_valid = 1; s2_jump_target = 32'h8;
        for (int k = 1; k <= 65538; k++) begin
            @(posedge clk); #1;
            if (k == 1 || k == 1000 || k == 65534 || k == 65535 || k == 65536 || k == 65538) begin
                check("sat_cnt",   32'(s2_cnt),   (k > 65535) ? 32'd65535 : 32'(k));
                check("sat_pc",    s2_pc,         32'(k) << 3);
                check("sat_flush", 32'(s2_fi & s2_fd), 32'h1);
                check("sat_redir", 32'(s2_redir), 32'h1);
            end
            @(negedge clk);
            s2_jump_target = 32'(k + 1) << 3;
        end
        s2_jump_valid = 0;
        @(posedge clk); #1;
        check("sat_flush_end", 32'(s2_fi | s2_fd | s2_redir), 32'h0);
    endtask

    initial begin
        fork
            main_seq();
            sat_seq();
        join
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
